// File: rtl/num_echo.sv
// num_echo: decimal number echo stage.
//
// Accepts ASCII characters over a ready/valid handshake and accumulates
// decimal digits into a binary value. On CR or LF it re-emits that value as
// canonical decimal text (leading zeros stripped), followed by CR LF. The
// output handshake is meant to feed a character FIFO directly.
//
// Parameters:
//   Width  - bit width of the accumulated value
//   Digits - maximum number of decimal digits emitted (10^Digits > 2^Width-1)
//
// Ports:
//   Clock        in   sole clock, rising edge
//   Reset        in   synchronous, active-high reset
//   DataIn       in   received ASCII character
//   DataInValid  in   DataIn valid
//   DataInReady  out  a character is accepted this cycle (registered)
//   DataOut      out  ASCII character to emit (registered)
//   DataOutValid out  DataOut valid (registered)
//   DataOutReady in   downstream accepts DataOut this cycle
//
// Build option:
//   NUM_ECHO_ERR_EN - when defined, a stray character or an accumulator
//   overflow marks the line as bad, and the line's terminator then emits
//   "E" CR LF. When undefined, stray characters are dropped and the
//   accumulator wraps modulo 2^Width.

module num_echo #(
  parameter int Width  = 16,
  parameter int Digits = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady
);

  // Remainder and power of ten use four extra bits so that acc*10+9 fits.
  localparam int WW = Width + 4;
  localparam int PW = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [PW-1:0] P_TOP = PW'(Digits - 1);

  typedef enum logic [2:0] {
    ACCUM      = 3'd0,
    CONVERT    = 3'd1,
    EMIT_DIGIT = 3'd2,
    EMIT_CR    = 3'd3,
    EMIT_LF    = 3'd4
`ifdef NUM_ECHO_ERR_EN
    , EMIT_ERR = 3'd5
`endif
  } state_t;

  // 10^e, built from a mux of constants because e only takes values below Digits.
  function automatic logic [WW-1:0] powTen(input logic [PW-1:0] e);
    logic [WW-1:0] r;
    r = WW'(1);
    for (int i = 0; i < Digits; i++) begin
      if (i < int'(e)) begin
        r = r * WW'(10);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t          state_r, nextState_s;
  logic [Width-1:0] acc_r, accNext_s;
  logic            seen_r, seenNext_s;
  logic [WW-1:0]   rem_r, remNext_s;
  logic [PW-1:0]   p_r, pNext_s;
  logic [3:0]      digit_r, digitNext_s;
  logic            started_r, startedNext_s;
  logic            dataInReady_r, dataInReadyNext_s;
  logic [7:0]      dataOut_r, dataOutNext_s;
  logic            dataOutValid_r, dataOutValidNext_s;

  logic            inXfer_s;
  logic            outXfer_s;
  logic            isDigit_s;
  logic            isTerm_s;
  logic [WW-1:0]   pow_s;
  logic [Width-1:0] accStep_s;

`ifdef NUM_ECHO_ERR_EN
  logic            err_r, errNext_s;
  logic [WW-1:0]   accWide_s;
  logic            overflow_s;
`endif

  assign DataInReady  = dataInReady_r;
  assign DataOut      = dataOut_r;
  assign DataOutValid = dataOutValid_r;

  assign inXfer_s  = DataInValid && dataInReady_r;
  assign outXfer_s = dataOutValid_r && DataOutReady;
  assign isDigit_s = (DataIn >= 8'h30) && (DataIn <= 8'h39);
  assign isTerm_s  = (DataIn == 8'h0D) || (DataIn == 8'h0A);
  assign pow_s     = powTen(p_r);

`ifdef NUM_ECHO_ERR_EN
  // Widened multiply-accumulate so an overflow past 2^Width-1 can be seen.
  assign accWide_s  = ({4'h0, acc_r} * WW'(10)) + {{(WW-4){1'b0}}, DataIn[3:0]};
  assign overflow_s = |accWide_s[WW-1:Width];
  assign accStep_s  = accWide_s[Width-1:0];
`else
  assign accStep_s  = (acc_r * Width'(10)) + {{(Width-4){1'b0}}, DataIn[3:0]};
`endif

  // State, datapath and registered-output flops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r        <= ACCUM;
      acc_r          <= {Width{1'b0}};
      seen_r         <= 1'b0;
      rem_r          <= {WW{1'b0}};
      p_r            <= {PW{1'b0}};
      digit_r        <= 4'd0;
      started_r      <= 1'b0;
      dataInReady_r  <= 1'b0;
      dataOut_r      <= 8'h00;
      dataOutValid_r <= 1'b0;
`ifdef NUM_ECHO_ERR_EN
      err_r          <= 1'b0;
`endif
    end else begin
      state_r        <= nextState_s;
      acc_r          <= accNext_s;
      seen_r         <= seenNext_s;
      rem_r          <= remNext_s;
      p_r            <= pNext_s;
      digit_r        <= digitNext_s;
      started_r      <= startedNext_s;
      dataInReady_r  <= dataInReadyNext_s;
      dataOut_r      <= dataOutNext_s;
      dataOutValid_r <= dataOutValidNext_s;
`ifdef NUM_ECHO_ERR_EN
      err_r          <= errNext_s;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    nextState_s   = state_r;
    accNext_s     = acc_r;
    seenNext_s    = seen_r;
    remNext_s     = rem_r;
    pNext_s       = p_r;
    digitNext_s   = digit_r;
    startedNext_s = started_r;
`ifdef NUM_ECHO_ERR_EN
    errNext_s     = err_r;
`endif
    case (state_r)
      ACCUM: begin
        if (inXfer_s) begin
          if (isDigit_s) begin
            accNext_s  = accStep_s;
            seenNext_s = 1'b1;
`ifdef NUM_ECHO_ERR_EN
            if (overflow_s) begin
              errNext_s = 1'b1;
            end else begin
              errNext_s = err_r;
            end
`endif
          end else if (isTerm_s) begin
`ifdef NUM_ECHO_ERR_EN
            if (err_r) begin
              nextState_s = EMIT_ERR;
            end else
`endif
            if (seen_r) begin
              nextState_s   = CONVERT;
              remNext_s     = {4'h0, acc_r};
              pNext_s       = P_TOP;
              digitNext_s   = 4'd0;
              startedNext_s = 1'b0;
            end else begin
              // Lone terminator (e.g. the LF of a CRLF pair): no blank line.
              nextState_s = ACCUM;
            end
          end else begin
`ifdef NUM_ECHO_ERR_EN
            errNext_s = 1'b1;
`else
            nextState_s = ACCUM;
`endif
          end
        end else begin
          nextState_s = ACCUM;
        end
      end
      CONVERT: begin
        // One subtraction of 10^p per cycle; the digit is final once rem < 10^p.
        if (rem_r >= pow_s) begin
          remNext_s   = rem_r - pow_s;
          digitNext_s = digit_r + 4'd1;
        end else if ((digit_r != 4'd0) || started_r || (p_r == {PW{1'b0}})) begin
          nextState_s = EMIT_DIGIT;
        end else begin
          // Leading zero: skip this position.
          pNext_s     = p_r - PW'(1);
          digitNext_s = 4'd0;
        end
      end
      EMIT_DIGIT: begin
        if (outXfer_s) begin
          startedNext_s = 1'b1;
          if (p_r == {PW{1'b0}}) begin
            nextState_s = EMIT_CR;
          end else begin
            pNext_s     = p_r - PW'(1);
            digitNext_s = 4'd0;
            nextState_s = CONVERT;
          end
        end else begin
          nextState_s = EMIT_DIGIT;
        end
      end
      EMIT_CR: begin
        if (outXfer_s) begin
          nextState_s = EMIT_LF;
        end else begin
          nextState_s = EMIT_CR;
        end
      end
      EMIT_LF: begin
        if (outXfer_s) begin
          nextState_s = ACCUM;
          accNext_s   = {Width{1'b0}};
          seenNext_s  = 1'b0;
`ifdef NUM_ECHO_ERR_EN
          errNext_s   = 1'b0;
`endif
        end else begin
          nextState_s = EMIT_LF;
        end
      end
`ifdef NUM_ECHO_ERR_EN
      EMIT_ERR: begin
        if (outXfer_s) begin
          nextState_s = EMIT_CR;
        end else begin
          nextState_s = EMIT_ERR;
        end
      end
`endif
      default: begin
        nextState_s = ACCUM;
      end
    endcase
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    dataInReadyNext_s  = (nextState_s == ACCUM);
    dataOutValidNext_s = 1'b0;
    dataOutNext_s      = 8'h00;
    case (nextState_s)
      EMIT_DIGIT: begin
        dataOutValidNext_s = 1'b1;
        dataOutNext_s      = 8'h30 + {4'h0, digitNext_s};
      end
      EMIT_CR: begin
        dataOutValidNext_s = 1'b1;
        dataOutNext_s      = 8'h0D;
      end
      EMIT_LF: begin
        dataOutValidNext_s = 1'b1;
        dataOutNext_s      = 8'h0A;
      end
`ifdef NUM_ECHO_ERR_EN
      EMIT_ERR: begin
        dataOutValidNext_s = 1'b1;
        dataOutNext_s      = 8'h45;
      end
`endif
      default: begin
        dataOutValidNext_s = 1'b0;
        dataOutNext_s      = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_num_echo.sv
// Testbench for num_echo: directed lines from the test plan plus random lines,
// checked against a text-level reference model of the echo behaviour.

module tb_num_echo;

  logic       Clock;
  logic       Reset;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;

  int assertCount = 0;
  int failCount   = 0;
  int outCount    = 0;
  int outReadyMode = 1;   // 0: hold low, 1: hold high, 2: random

  byte expQ[$];
  longint mAcc = 0;
  bit     mSeen = 0;
  bit     mErr  = 0;

  num_echo #(.Width(16), .Digits(5)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .DataOut     (DataOut),
    .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushStr(input string s);
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
  endtask

  task automatic modelReset();
    mAcc = 0; mSeen = 0; mErr = 0;
  endtask

  // Reference behaviour per accepted character, in plain arithmetic and text.
  task automatic modelChar(input logic [7:0] c);
    if (c >= "0" && c <= "9") begin
      mAcc  = mAcc * 10 + (c - 8'h30);
      mSeen = 1;
      if (mAcc > 65535) begin
`ifdef NUM_ECHO_ERR_EN
        mErr = 1;
`endif
        mAcc = mAcc % 65536;
      end
    end else if (c == 8'h0D || c == 8'h0A) begin
      if (mErr) pushStr("E\r\n");
      else if (mSeen) pushStr($sformatf("%0d\r\n", mAcc));
      modelReset();
    end else begin
`ifdef NUM_ECHO_ERR_EN
      mErr = 1;
`endif
    end
  endtask

  task automatic sendChar(input logic [7:0] c);
    int n = 0;
    DataIn = c;
    DataInValid = 1'b1;
    while (1) begin
      @(negedge Clock);
      if (DataInReady) break;
      n++;
      if (n > 3000) begin
        checkValue("inTimeout", n, 0);
        DataInValid = 1'b0;
        return;
      end
    end
    @(posedge Clock);
    #1;
    DataInValid = 1'b0;
    DataIn = $urandom_range(0, 255);
    modelChar(c);
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i]);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    checkValue(tag, expQ.size(), 0);
    @(posedge Clock);
    #1;
    checkValue({tag, "_ready"}, DataInReady, 1);
  endtask

  // Downstream ready generator.
  initial begin
    DataOutReady = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      case (outReadyMode)
        0:       DataOutReady = 1'b0;
        1:       DataOutReady = 1'b1;
        default: DataOutReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: scoreboard, hold-while-stalled and no-input-while-emitting checks.
  initial begin
    bit       prevStall = 0;
    logic [7:0] prevData = 8'h00;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prevStall = 0;
      end else begin
        if (prevStall) begin
          checkValue("holdValid", DataOutValid, 1);
          checkValue("holdData", DataOut, prevData);
        end
        if (DataOutValid) checkValue("inReadyWhileOut", DataInReady, 0);
        if (DataOutValid && DataOutReady) begin
          outCount++;
          if (expQ.size() == 0) checkValue("spuriousOut", expQ.size(), 1);
          else checkValue("outChar", DataOut, expQ.pop_front());
        end
        prevStall = DataOutValid && !DataOutReady;
        prevData  = DataOut;
      end
    end
  end

  initial begin
    int n;
    int base;
    Reset = 1'b1;
    DataIn = 8'h00;
    DataInValid = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checkValue("rstReady", DataInReady, 0);
    checkValue("rstValid", DataOutValid, 0);
    checkValue("rstData", DataOut, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    checkValue("readyAfterRst", DataInReady, 1);

    // "123\r" with first-output latency bound.
    outReadyMode = 1;
    sendStr("123\r");
    n = 0;
    while (!DataOutValid && n < 60) begin
      @(posedge Clock);
      #1;
      n++;
    end
    checkValue("firstLatencyOk", (n <= 52), 1);
    waitDrain("line123");

    outReadyMode = 2;
    sendStr("007\r\n"); waitDrain("line007");
    sendStr("0\r");     waitDrain("line0");
    sendStr("65535\r"); waitDrain("line65535");
    sendStr("65536\r"); waitDrain("line65536");
    sendStr("1a2\r");   waitDrain("line1a2");

    // Back-pressure: hold DataOutReady low for 20 cycles after first valid.
    outReadyMode = 0;
    sendStr("42\r");
    n = 0;
    while (!DataOutValid && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checkValue("stallValidSeen", DataOutValid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      checkValue("stallData", DataOut, 8'h34);
      checkValue("stallValid", DataOutValid, 1);
      checkValue("stallInReady", DataInReady, 0);
    end
    outReadyMode = 2;
    waitDrain("line42");

    // Reset in the middle of emitting "12345".
    outReadyMode = 1;
    base = outCount;
    sendStr("12345\r");
    n = 0;
    while (outCount < base + 2 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    checkValue("midResetReached", outCount - base, 2);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    expQ.delete();
    modelReset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    checkValue("midRstValid", DataOutValid, 0);
    checkValue("midRstReady", DataInReady, 0);
    @(posedge Clock);
    #1;
    checkValue("midRstReadyAfter", DataInReady, 1);
    sendStr("9\r");
    waitDrain("line9");

    // Random lines: digits, occasional stray characters and mixed terminators.
    outReadyMode = 2;
    for (int l = 0; l < 40; l++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) sendChar(8'h61 + 8'($urandom_range(0, 5)));
        else sendChar(8'h30 + 8'($urandom_range(0, 9)));
      end
      case ($urandom_range(0, 2))
        0:       sendStr("\r");
        1:       sendStr("\n");
        default: sendStr("\r\n");
      endcase
      if ($urandom_range(0, 3) == 0) waitDrain("randLine");
    end
    waitDrain("randFinal");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/num_echo.md
# num_echo

Decimal number echo stage between the UART receive side and the character FIFO feeding the UART transmitter. Accepts ASCII characters over a ready/valid handshake, accumulates decimal digits into a binary value, and on a line terminator emits the value in canonical decimal (leading zeros stripped) followed by CR LF. Output handshake connects directly to the CharFifo input.

## Interface

- `Width`, 16, bit width of the accumulated value.
- `Digits`, 5, maximum decimal digits emitted; must satisfy 10^Digits > 2^Width-1.
- `Clock`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `DataIn`  in  8  received ASCII character.
- `DataInValid`  in  1  DataIn valid.
- `DataInReady`  out  1  block accepts a character this cycle.
- `DataOut`  out  8  ASCII character to emit.
- `DataOutValid`  out  1  DataOut valid.
- `DataOutReady`  in  1  downstream accepts DataOut this cycle.

## Operation

- States: ACCUM, CONVERT, EMIT_DIGIT, EMIT_CR, EMIT_LF, EMIT_ERR.
- ACCUM: DataInReady=1; transfer when DataInValid && DataInReady.
  - '0'..'9' (0x30-0x39): acc <= acc*10 + (c-0x30), computed at Width+4 bits; seen <= 1.
  - CR (0x0D) or LF (0x0A) with seen=1: go to CONVERT (or EMIT_ERR if err flag set). With seen=0: discarded; stay in ACCUM (CRLF pair never yields blank line).
  - Any other character: handled per Configuration.
- CONVERT/EMIT_DIGIT: p runs Digits-1 down to 0; digit found by repeated subtraction of 10^p, one subtraction per cycle. Leading zero digits suppressed; digit at p=0 always emitted (value 0 -> "0"). Each non-suppressed digit presented as 0x30+d in EMIT_DIGIT until transferred.
- EMIT_CR emits 0x0D, EMIT_LF emits 0x0A; after LF transfer: acc, seen, err cleared; return to ACCUM.
- EMIT_ERR: emits error character, then EMIT_CR, EMIT_LF.
- DataInReady=0 in every state except ACCUM; no input is buffered during output.

## Timing

- During Reset and the cycle it is sampled: DataInReady=0, DataOutValid=0, DataOut=8'h00, acc=0, seen=0, err=0, state=ACCUM. DataInReady=1 on the first cycle after Reset deasserts.
- All outputs registered.
- Output handshake: transfer on DataOutValid && DataOutReady. While DataOutValid=1 and DataOutReady=0, DataOut held stable and DataOutValid stays 1. DataOutValid never drops without a transfer, except on Reset.
- Terminator accepted at edge N: first output character valid no later than N + 10*Digits + 2 cycles.
- Between characters, with DataOutReady held 1: at most 11 cycles.
- CR/LF emission has 1-cycle gap max after previous transfer.
- Reset mid-conversion or mid-emit: output abandoned immediately, no partial line completion; next cycle follows reset values above.
- DataInValid may be asserted in any state; the character is held by upstream until DataInReady.

## Configuration

- Macro `NUM_ECHO_ERR_EN`.
- Defined: any non-digit, non-terminator character sets err; acc overflow (result > 2^Width-1) sets err; err is sticky until line end. A line with err=1 emits "E" (0x45) CR LF, regardless of seen, on its terminator.
- Undefined: non-digit, non-terminator characters accepted and discarded; acc wraps modulo 2^Width; EMIT_ERR state absent.

## Test plan

- "123\r" -> DataOut sequence 0x31,0x32,0x33,0x0D,0x0A; then DataInReady=1.
- "007\r\n" -> 0x37,0x0D,0x0A only; trailing LF discarded, no blank line. "0\r" -> 0x30,0x0D,0x0A.
- "65535\r" -> "65535\r\n". "65536\r" -> "E\r\n" with NUM_ECHO_ERR_EN, "0\r\n" without.
- "1a2\r" -> "E\r\n" with NUM_ECHO_ERR_EN, "12\r\n" without.
- "42\r" with DataOutReady held 0 for 20 cycles after first DataOutValid -> DataOut=0x34 stable, DataOutValid=1 throughout, DataInReady=0; release -> "42\r\n" completes.
- Reset asserted one cycle while emitting "12345\r\n" after '2' transferred -> next cycle DataOutValid=0, DataInReady=0; then DataInReady=1; "9\r" -> "9\r\n".
